// File: rtl/pixel_kernel_sched.sv
// Pixel kernel scheduler.
// Walks N_PIXELS pixel FSMs one after another through a fixed schedule:
// a one-cycle start pulse, the local-integration timer, the adjacent-exchange
// timer, then a wait for the pixel's done level, guarded by a watchdog.
//
// Ports:
//   clk, reset         single clock, synchronous active-high reset
//   start, abort       run request (honoured in idle only) / synchronous abort
//   cfg_loc_max        local-timer length, latched when a run starts
//   cfg_adj_max        adjacent-timer length, latched when a run starts
//   pxl_done_i         per-pixel done levels; only the current pixel is looked at
//   pxl_start          one-hot start pulse to the current pixel
//   loc_timer_en/_max  local timer running / last local-timer cycle
//   adj_timer_en/_max  adjacent timer running / last adjacent-timer cycle
//   cur_pixel          index of the pixel being serviced
//   busy               scheduler not idle
//   kernel_done        one-cycle pulse once the last pixel completes
//   err_timeout        sticky watchdog error, cleared by the next start
module pixel_kernel_sched #(
  parameter int unsigned N_PIXELS = 4,
  parameter int unsigned CNT_W    = 10,
  parameter int unsigned TIMEOUT  = 1023
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [CNT_W-1:0]    cfg_loc_max,
  input  logic [CNT_W-1:0]    cfg_adj_max,
  input  logic [N_PIXELS-1:0] pxl_done_i,
  output logic [N_PIXELS-1:0] pxl_start,
  output logic                loc_timer_en,
  output logic                loc_timer_max,
  output logic                adj_timer_en,
  output logic                adj_timer_max,
  output logic [3:0]          cur_pixel,
  output logic                busy,
  output logic                kernel_done,
  output logic                err_timeout
);

  localparam int unsigned WdW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {StIdle, StStart, StLoc, StAdj, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WdW-1:0]    wd_q, wd_d;
  logic [3:0]        cur_q, cur_d;
  logic [CNT_W-1:0]  loc_max_q, loc_max_d;
  logic [CNT_W-1:0]  adj_max_q, adj_max_d;
  logic              err_q, err_d;

  logic [N_PIXELS-1:0] cur_sel;
  logic                done_cur;
  logic                loc_last, adj_last, wd_last;

  // Decode the current pixel index once; drives both the start pulse and
  // the done select so other pixels' done bits never matter.
  always_comb begin
    for (int i = 0; i < N_PIXELS; i++) begin
      cur_sel[i] = (cur_q == 4'(i));
    end
  end

  assign done_cur = |(pxl_done_i & cur_sel);
  // Compare against max-1 rather than counting to max so max = all-ones
  // never needs a wider counter.
  assign loc_last = (cnt_q == loc_max_q - CNT_W'(1));
  assign adj_last = (cnt_q == adj_max_q - CNT_W'(1));
  assign wd_last  = (wd_q == WdW'(TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wd_d      = '0;
    cur_d     = cur_q;
    loc_max_d = loc_max_q;
    adj_max_d = adj_max_q;
    err_d     = err_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          loc_max_d = cfg_loc_max;
          adj_max_d = cfg_adj_max;
          err_d     = 1'b0;
          cur_d     = '0;
          state_d   = StStart;
        end
      end
      StStart: begin
        cnt_d = '0;
        if (loc_max_q != '0)      state_d = StLoc;
        else if (adj_max_q != '0) state_d = StAdj;
        else                      state_d = StWait;
      end
      StLoc: begin
        if (loc_last) begin
          cnt_d   = '0;
          state_d = (adj_max_q != '0) ? StAdj : StWait;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StAdj: begin
        if (adj_last) begin
          cnt_d   = '0;
          state_d = StWait;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StWait: begin
        // Done is checked first so it wins over a simultaneous timeout.
        if (done_cur) begin
          if (cur_q == 4'(N_PIXELS - 1)) begin
            state_d = StDone;
          end else begin
            cur_d   = cur_q + 4'd1;
            state_d = StStart;
          end
        end else if (wd_last) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          wd_d = wd_q + WdW'(1);
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Abort overrides everything, including a start seen in idle.
    if (abort) begin
      state_d   = StIdle;
      cnt_d     = '0;
      wd_d      = '0;
      cur_d     = cur_q;
      loc_max_d = loc_max_q;
      adj_max_d = adj_max_q;
      err_d     = err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      wd_q      <= '0;
      cur_q     <= '0;
      loc_max_q <= '0;
      adj_max_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wd_q      <= wd_d;
      cur_q     <= cur_d;
      loc_max_q <= loc_max_d;
      adj_max_q <= adj_max_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    pxl_start     = (state_q == StStart) ? cur_sel : '0;
    loc_timer_en  = (state_q == StLoc);
    loc_timer_max = (state_q == StLoc) && loc_last;
    adj_timer_en  = (state_q == StAdj);
    adj_timer_max = (state_q == StAdj) && adj_last;
    busy          = (state_q != StIdle);
    kernel_done   = (state_q == StDone);
    cur_pixel     = cur_q;
    err_timeout   = err_q;
  end

endmodule

// File: doc/pixel_kernel_sched.md
Name: pixel_kernel_sched

Overview:
Scheduler that sequences a kernel of N pixel FSMs through a fixed per-pixel schedule: start pulse, local-integration timer, adjacent-exchange timer, then wait for the pixel's done.
- Drives the pxl_start / loc_timer / adj_timer / kernel_done handshakes that the single pixel FSM currently gets from the logic analyser.
- Sits between the Wishbone control register (cfg inputs) and an array of pixel instances inside the pixel macro.

Parameters:
N_PIXELS, 4, number of pixel FSMs sequenced (2..16).
CNT_W, 10, width of loc/adj timer counters and cfg values.
TIMEOUT, 1023, max cycles spent in WAIT_DONE before abort with error.

Ports:
clk  input  1  single clock.
reset  input  1  synchronous, active-high reset.
start  input  1  request a kernel run; sampled only in IDLE.
abort  input  1  synchronous abort; returns to IDLE next cycle.
cfg_loc_max  input  CNT_W  local-timer length in cycles; latched at start.
cfg_adj_max  input  CNT_W  adjacent-timer length in cycles; latched at start.
pxl_done_i  input  N_PIXELS  per-pixel done level.
pxl_start  output  N_PIXELS  one-hot start pulse to the current pixel.
loc_timer_en  output  1  high while the local timer runs.
loc_timer_max  output  1  one-cycle pulse on the last local-timer cycle.
adj_timer_en  output  1  high while the adjacent timer runs.
adj_timer_max  output  1  one-cycle pulse on the last adjacent-timer cycle.
cur_pixel  output  4  index of the pixel being serviced.
busy  output  1  state != IDLE.
kernel_done  output  1  one-cycle pulse after the last pixel completes.
err_timeout  output  1  sticky watchdog error flag.

Behaviour:
- Reset (priority over everything): state=IDLE.
  - All outputs 0, cur_pixel=0, counters 0, err_timeout=0.
- States: IDLE, START, LOC, ADJ, WAIT_DONE, DONE. All outputs are registered or decoded from registered state.
- IDLE:
  - On start=1 at edge E: latch cfg_loc_max and cfg_adj_max, clear err_timeout, set cur_pixel=0, go START.
  - start in any other state is ignored.
- START: exactly 1 cycle, pxl_start[cur_pixel]=1.
  - Next state is LOC if loc_max!=0, else ADJ if adj_max!=0, else WAIT_DONE.
- LOC:
  - Counter runs 0..loc_max-1, one cycle per count; loc_timer_en=1 throughout.
  - loc_timer_max=1 when count==loc_max-1.
  - Then go to ADJ, or WAIT_DONE if adj_max==0. Counter clears on exit.
- ADJ: same as LOC, using adj_max, adj_timer_en and adj_timer_max.
- WAIT_DONE:
  - Watchdog counts cycles from 0.
  - If pxl_done_i[cur_pixel]=1: when cur_pixel==N_PIXELS-1 go DONE; otherwise cur_pixel+1 and go START. A done already high on entry costs 1 cycle.
  - If the watchdog reaches TIMEOUT-1 with done still low: set err_timeout=1 and go IDLE; no kernel_done.
  - Done and timeout in the same cycle: done wins.
  - pxl_done_i bits of non-current pixels are ignored.
- DONE: kernel_done=1 for 1 cycle, then IDLE. cur_pixel holds its last value until the next start.
- Per-pixel latency: 1 + loc_max + adj_max + W cycles, where W>=1 is the WAIT_DONE dwell.
- Abort (any non-IDLE state):
  - Next state IDLE; all pulses/enables 0 from the next cycle; counters cleared; no kernel_done; err_timeout unchanged.
  - Abort and start together in IDLE: abort wins, start dropped.
- Counters are CNT_W bits; loc_max/adj_max = 2^CNT_W-1 must run the full count without wrap.
- cfg changes while busy have no effect until the next start.

Test Plan:
1. Reset, then start with N=4, loc=3, adj=2, done tied high.
   - pxl_start[k] pulses after edges 0, 7, 14, 21.
   - loc_timer_en is 3 cycles and adj_timer_en 2 cycles per pixel; max pulses on their last cycles.
   - kernel_done is a single pulse after edge 28; busy then falls.
2. loc=0, adj=0, done high: each pixel takes 2 cycles (START, WAIT); no timer enables or max pulses ever; kernel_done after edge 8.
3. loc=1, adj=1, pixel 2 done delayed 5 cycles in WAIT_DONE: cur_pixel holds 2 for 5 wait cycles, pixel 3 then starts, kernel_done follows; err_timeout=0.
4. TIMEOUT=8, pixel 1 done held low:
   - err_timeout sets after 8 WAIT_DONE cycles, state returns to IDLE, kernel_done never pulses, pxl_start[2] never pulses.
   - A fresh start clears err_timeout.
5. Abort in the second LOC cycle of pixel 0: next cycle busy=0 and loc_timer_en=0, with no kernel_done. A start while busy is ignored. Start and abort together in IDLE leave busy=0.
6. Change cfg_loc_max from 3 to 7 mid-run: remaining pixels still use 3. Reset asserted mid-ADJ gives all outputs 0 on the next cycle.
